// File: rtl/nibble_serial_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package nibble_serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } nsa_state_t;

  localparam int NIBBLE_W = 4;

endpackage

// File: rtl/nibble_serial_adder_ctrl_rca4.sv
// 4-bit ripple-carry adder: the single shared arithmetic element of the sequencer.
module nibble_serial_adder_ctrl_rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic c;

  always_comb begin
    // NOTE: blocking assignments here build a combinational chain; every output gets a value on every pass, so no latch.
    c = cin;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-precision adder sequencer: adds WIDTH-bit operands one nibble per cycle
// through one shared 4-bit adder. Optional subtract mode: NIBBLE_SERIAL_SUB_EN.
module nibble_serial_adder_ctrl
  import nibble_serial_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_bad_width
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  nsa_state_t         state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx;
  logic [NIBBLE_W-1:0] nib_s;
  logic               nib_c;
  logic               sub_op;

`ifdef NIBBLE_SERIAL_SUB_EN
  assign sub_op = sub;
`else
  assign sub_op = 1'b0;
`endif

  nibble_serial_adder_ctrl_rca4 u_rca4 (
    .a    (a_q[idx*NIBBLE_W +: NIBBLE_W]),
    .b    (b_q[idx*NIBBLE_W +: NIBBLE_W]),
    .cin  (carry_q),
    .s    (nib_s),
    .cout (nib_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (idx == LAST_IDX) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode straight from the state register.
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: operand and result registers are plain flops, not a memory, so all of them clear on reset.
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub_op ? ~b : b;
            carry_q <= sub_op ? 1'b1 : cin;
            idx     <= '0;
          end
        end
        RUN: begin
          sum[idx*NIBBLE_W +: NIBBLE_W] <= nib_s;
          carry_q <= nib_c;
          if (idx == LAST_IDX) begin
            cout <= nib_c;
            idx  <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (WIDTH=16): vector table,
// randomized ops against an arithmetic model, and handshake/reset corner cases.
module tb_nibble_serial_adder_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef NIBBLE_SERIAL_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on whole operands.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c, input logic s);
    int unsigned xi, yi;
    xi = x;
    yi = y;
    if (s) return {(xi >= yi), W'((xi - yi) % (1 << W))};
    return (W+1)'(xi + yi + c);
  endfunction

  // Issue one op with a one-cycle start pulse; report result, latency and busy cycles.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic ts, output logic [W-1:0] rs, output logic rc,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    rs = sum;
    rc = cout;
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  vec_t vecs[8];
  logic [W-1:0] rs;
  logic         rc;
  int           lat, bc;
  logic [W:0]   exp;
  logic [W-1:0] ra, rb;
  logic         rcin;
  int           done_seen;

  initial begin
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[5] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0};
    vecs[6] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
    vecs[7] = '{16'hF0F0, 16'h0F0F, 1'b1, 16'h0000, 1'b1};

    // Reset state
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_sum",  {16'd0, sum},  32'd0);
    check("reset_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, rs, rc, lat, bc);
      check($sformatf("vec%0d_sum", i),  {16'd0, rs}, {16'd0, vecs[i].exp_sum});
      check($sformatf("vec%0d_cout", i), {31'd0, rc}, {31'd0, vecs[i].exp_cout});
      check($sformatf("vec%0d_latency", i), lat, 5);
      check($sformatf("vec%0d_busy_cycles", i), bc, 4);
    end

    // Result holds while idle
    repeat (3) @(posedge clk);
    #1;
    check("hold_sum",  {16'd0, sum},  {16'd0, vecs[7].exp_sum});
    check("hold_cout", {31'd0, cout}, {31'd0, vecs[7].exp_cout});

    // Randomized ops against the model
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rcin = 1'($urandom);
      exp = model(ra, rb, rcin, 1'b0);
      run_op(ra, rb, rcin, 1'b0, rs, rc, lat, bc);
      check($sformatf("rand%0d_sum", i),  {16'd0, rs}, {16'd0, exp[W-1:0]});
      check($sformatf("rand%0d_cout", i), {31'd0, rc}, {31'd0, exp[W]});
    end

    // start held high; operands change during RUN
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 16'h0000; b = 16'h0000;
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("held_latency", lat, 5);
    check("held_sum",  {16'd0, sum},  32'h0000);
    check("held_cout", {31'd0, cout}, 32'd1);
    @(posedge clk); #1;
    check("held_idle_busy", {31'd0, busy}, 32'd0);
    check("held_idle_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    check("held_second_accept", {31'd0, busy}, 32'd1);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("held_second_latency", lat, 5);
    check("held_second_sum",  {16'd0, sum},  32'h0000);
    check("held_second_cout", {31'd0, cout}, 32'd0);
    @(posedge clk); #1;

    // Reset during the second RUN cycle
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("abort_in_run", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sum",  {16'd0, sum},  32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    run_op(16'h0FFF, 16'h0001, 1'b0, 1'b0, rs, rc, lat, bc);
    check("post_abort_sum",  {16'd0, rs}, 32'h1000);
    check("post_abort_cout", {31'd0, rc}, 32'd0);
    check("post_abort_latency", lat, 5);

`ifdef NIBBLE_SERIAL_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, rs, rc, lat, bc);
    check("sub_5_7_sum",  {16'd0, rs}, 32'hFFFE);
    check("sub_5_7_cout", {31'd0, rc}, 32'd0);
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, rs, rc, lat, bc);
    check("sub_7_5_sum",  {16'd0, rs}, 32'h0002);
    check("sub_7_5_cout", {31'd0, rc}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rcin = 1'($urandom);
      exp = model(ra, rb, rcin, 1'b1);
      run_op(ra, rb, rcin, 1'b1, rs, rc, lat, bc);
      check($sformatf("rsub%0d_sum", i),  {16'd0, rs}, {16'd0, exp[W-1:0]});
      check($sformatf("rsub%0d_cout", i), {31'd0, rc}, {31'd0, exp[W]});
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Multi-precision adder sequencer. It adds two WIDTH-bit operands over WIDTH/4 cycles, one nibble per cycle, using a single 4-bit ripple-carry adder instance. The carry is held in a register between nibbles. It trades latency for area and sits between a requesting datapath and the shared 4-bit adder, with a start/busy/done handshake.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4; elaboration error otherwise.
- NIB (localparam), WIDTH/4, number of nibble steps.
- IDX_W (localparam), max(1, $clog2(NIB)), nibble index counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured when start is accepted.
- b  in  WIDTH  operand B; captured when start is accepted.
- cin  in  1  carry-in to nibble 0; captured when start is accepted.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  registered result.
- cout  out  1  registered carry-out of the top nibble.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, sum=0, cout=0, idx=0, carry_q=0, operand registers=0.
- States:
  - IDLE: on start=1 at edge E0, latch a_q<=a, b_q<=b, carry_q<=cin, idx<=0, go to RUN.
  - RUN: at each edge E1..E_NIB:
    - Adder inputs are a_q[idx*4+:4], b_q[idx*4+:4] and carry_q.
    - sum[idx*4+:4]<=s; carry_q<=adder cout; idx<=idx+1.
    - At E_NIB (idx==NIB-1): cout<=adder cout, go to DONE.
  - DONE: done=1 for exactly this one cycle; next edge goes to IDLE.
- Latency: done is high in the cycle after edge E_NIB. With WIDTH=16 that is 5 edges after start is sampled. Throughput is one operation per NIB+2 cycles.
- busy=1 only in RUN; done=1 only in DONE. Both decode directly from the state register, with no combinational path from inputs.
- start is ignored while in RUN or DONE, with no queuing. Operand changes after capture have no effect.
- sum and cout may change during RUN. They are valid from the done cycle and hold until the next accepted start.
- Wrap-around: carry out of the top nibble appears only on cout. sum wraps modulo 2^WIDTH.
- idx never exceeds NIB-1, and there is no out-of-range slice select.
- Reset mid-RUN aborts immediately: all outputs return to reset values and no done pulse is produced.
- WIDTH=4: a single RUN cycle; the IDX_W=1 counter stays 0.

Optional Feature:
- Macro: NIBBLE_SERIAL_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with the operands.
  - When sub=1: b_q is stored inverted (~b) and carry_q is initialised to 1, ignoring cin, so sum = a - b mod 2^WIDTH and cout = 1 means no borrow.
  - When sub=0: identical to the undefined case.
- Undefined: no sub port; add only.

Decomposition:
- Package nibble_serial_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} nsa_state_t.
  - localparam NIBBLE_W=4.
- Sub-module: the team's existing 4-bit ripple-carry adder (ports a[3:0], b[3:0], cin, s[3:0], cout), instantiated once as the sole arithmetic element. No other sub-modules.

Test Plan (WIDTH=16):
- a=0x1234, b=0x4321, cin=0, start pulse -> busy high 4 cycles; done 5 edges after start; sum=0x5555, cout=0.
- a=0x0FFF, b=0x0001, cin=0 -> carry ripples through 3 nibbles; sum=0x1000, cout=0. Also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
- a=0xFFFF, b=0x0001 with start held high across the operation, and a/b changed to 0x0000 during RUN -> single op; sum=0x0000, cout=1; second start accepted only after returning to IDLE.
- rst_n pulsed low during the 2nd RUN cycle -> busy, done, sum and cout drop to 0 asynchronously; no done pulse; next start completes normally.
- NIBBLE_SERIAL_SUB_EN defined:
  - sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0.
  - sub=1, a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
